// File: rtl/count_sequencer.sv
// count_sequencer: command-driven load/run controller for an external loadable counter.
// Optional build macro SEQ_TIMEOUT_EN adds a RUN-phase watchdog with a sticky err flag.
`default_nettype none

module count_sequencer #(
  parameter int         WIDTH       = 8,
  parameter logic [2:0] LOAD_CODE   = 3'd1,
  parameter int         TIMEOUT_CYC = 300
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt,
  output logic             ena,
  output logic [2:0]       load,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] end_r;
  logic [2:0]       load_r;
  logic             busy_r;
  logic             done_r;
  logic             accept;
  logic             at_end;
  logic             timeout_hit;

  // abort wins over a handshake presented on the same edge
  assign accept    = (state == S_IDLE) && cmd_valid && !abort;
  assign at_end    = (cnt == end_r);
  assign cmd_ready = (state == S_IDLE);

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] run_cyc;
  logic          err_r;

  assign timeout_hit = (state == S_RUN) && !at_end && (run_cyc == TW'(TIMEOUT_CYC - 1));
  assign err         = err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cyc <= '0;
      err_r   <= 1'b0;
    end else begin
      if (state != S_RUN) begin
        run_cyc <= '0;
      end else begin
        run_cyc <= run_cyc + 1'b1;
      end
      if (accept) begin
        err_r <= 1'b0;
      end else if (timeout_hit) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort || timeout_hit) begin
          state_nxt = S_IDLE;
        end else if (at_end) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // enable is combinational so the counter stops exactly on end_r and abort cuts it at once
  always_comb begin
    ena = 1'b0;
    if (!abort) begin
      case (state)
        S_LOAD:  ena = 1'b1;
        S_RUN:   ena = !at_end && !timeout_hit;
        default: ena = 1'b0;
      endcase
    end
  end

  assign load = abort ? 3'd0 : load_r;
  assign data = data_r;
  assign busy = busy_r;
  assign done = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      data_r <= '0;
      end_r  <= '0;
      load_r <= 3'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_r <= cmd_start;
        end_r  <= cmd_end;
      end
      load_r <= (state_nxt == S_LOAD) ? LOAD_CODE : 3'd0;
      busy_r <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      done_r <= (state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scoreboard bench; models the loadable counter around the DUT.
`default_nettype none

module tb_count_sequencer;

  localparam int         W  = 8;
  localparam logic [2:0] LC = 3'd1;
  localparam int         TO = 20;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         abort     = 1'b0;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_end   = '0;
  logic [W-1:0] cnt;
  logic         cmd_ready;
  logic         ena;
  logic [2:0]   load;
  logic [W-1:0] data;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit freeze = 1'b0;

  typedef struct {
    int         done_cyc;
    logic [7:0] fin;
    int         runlen;
  } exp_t;

  exp_t exp_q[$];

  count_sequencer #(.WIDTH(W), .LOAD_CODE(LC), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_end  (cmd_end),
    .abort    (abort),
    .cnt      (cnt),
    .ena      (ena),
    .load     (load),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // the counter datapath the sequencer drives
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load != 3'd0) cnt <= data;
    else if (ena && !freeze) cnt <= cnt + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] e, input bit keep);
    exp_t x;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_end   = e;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    x.runlen   = int'(8'(e - s));
    x.done_cyc = cyc + 3 + x.runlen;
    x.fin      = e;
    exp_q.push_back(x);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    check("load_code", 32'(load), 32'(LC));
    check("load_data", 32'(data), 32'(s));
    check("load_ena", 32'(ena), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int   en   = 0;
    int   viol = 0;
    bit   seen = 1'b0;
    exp_t x;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (ena && load == 3'd0) en++;
      if (cmd_ready) viol++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    x = exp_q.pop_front();
    check({tag, "_done_cycle"}, 32'(cyc), 32'(x.done_cyc));
    check({tag, "_final_cnt"}, 32'(cnt), 32'(x.fin));
    check({tag, "_ena_cycles"}, 32'(en), 32'(x.runlen));
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_ena"}, 32'(ena), 32'd0);
    check({tag, "_ready_while_busy"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int   dn;
    exp_t x;

    #1 rst_n = 1'b0;
    #1;
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic 0 -> 8
    send(8'd0, 8'd8, 1'b0);
    wait_done("basic");
    @(negedge clk);
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_back_idle", 32'(cmd_ready), 32'd1);

    // wrap 250 -> 4 through FF -> 00
    send(8'd250, 8'd4, 1'b0);
    wait_done("wrap");

    // zero-length run
    send(8'h55, 8'h55, 1'b0);
    wait_done("zero");

    // valid held through the run: second command only after DONE
    send(8'd0, 8'd8, 1'b1);
    cmd_start = 8'h10;
    cmd_end   = 8'h12;
    wait_done("busy1");
    @(negedge clk);
    check("busy_idle_ready", 32'(cmd_ready), 32'd1);
    x.runlen   = 2;
    x.done_cyc = cyc + 3 + 2;
    x.fin      = 8'h12;
    exp_q.push_back(x);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy2_load", 32'(load), 32'(LC));
    check("busy2_data", 32'(data), 32'h10);
    wait_done("busy2");

    // abort at cnt==3
    send(8'd0, 8'd8, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (cnt == 8'd3) break;
      @(negedge clk);
    end
    check("abort_reach_3", 32'(cnt), 32'd3);
    abort = 1'b1;
    #1;
    check("abort_ena", 32'(ena), 32'd0);
    check("abort_load", 32'(load), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(cmd_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt_held", 32'(cnt), 32'd3);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    void'(exp_q.pop_front());

    // reset mid-run
    send(8'd0, 8'd8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ena", 32'(ena), 32'd0);
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd3, 8'd5, 1'b0);
    wait_done("post_reset");

`ifdef SEQ_TIMEOUT_EN
    // frozen counter never reaches end -> watchdog
    freeze = 1'b1;
    send(8'd0, 8'd8, 1'b0);
    dn = 0;
    begin
      int runc = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (err) break;
        if (done) dn++;
        if (busy && load == 3'd0) runc++;
      end
      check("to_run_cycles", 32'(runc), 32'(TO));
    end
    check("to_err", 32'(err), 32'd1);
    check("to_no_done", 32'(dn), 32'd0);
    check("to_idle", 32'(cmd_ready), 32'd1);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    freeze = 1'b0;
    send(8'd1, 8'd2, 1'b0);
    check("to_err_cleared", 32'(err), 32'd0);
    wait_done("after_timeout");
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
